// File: rtl/keypad_scanner.sv
// Row-strobed matrix keypad scanner: synchronised, debounced columns, one encoded event per press into a FIFO.
// Event visible the cycle after the debounce-complete tick; held by key_ready backpressure, dropped with an overflow pulse when full.
module keypad_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 8,
    parameter int DEBOUNCE_CNT = 3,
    parameter int FIFO_DEPTH   = 4,
    parameter int MAP_HEX      = 1,
    parameter int KW           = ($clog2(ROWS * COLS) < 4) ? 4 : $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [COLS-1:0] column,
    output logic [ROWS-1:0] row,
    output logic [KW-1:0]   key_code,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            key_held,
    output logic            overflow
);
    localparam int RIW = $clog2(ROWS);
    localparam int CIW = $clog2(COLS);
    localparam int PW  = $clog2(SCAN_DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [3:0] DB = 4'(DEBOUNCE_CNT);
    localparam bit USE_HEX = (MAP_HEX == 1) && (ROWS == 4) && (COLS == 4);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    logic [COLS-1:0] col_s1, col_s;
    logic [PW-1:0]   presc;
    logic            tick;
    logic            any_low;
    logic [CIW-1:0]  low_col;
    state_t          state, state_d;
    logic [RIW-1:0]  row_idx, row_idx_d, row_adv;
    logic [CIW-1:0]  col_lat, col_lat_d;
    logic [3:0]      cnt, cnt_d, cnt_inc;
    logic            push;
    logic [KW-1:0]   raw_code, push_code;
    logic [3:0]      hex_code;

    logic [KW-1:0]   mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            fifo_empty, fifo_full, pop, push_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1 <= '1;
            col_s  <= '1;
            presc  <= '0;
        end else begin
            col_s1 <= column;
            col_s  <= col_s1;
            presc  <= tick ? '0 : presc + PW'(1);
        end
    end

    assign tick = (presc == PW'(SCAN_DIV - 1));

    // Lowest-index low column wins when several keys share the strobed row.
    always_comb begin
        any_low = 1'b0;
        low_col = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!col_s[c]) begin
                any_low = 1'b1;
                low_col = CIW'(c);
            end
        end
    end

    assign row_adv = (row_idx == RIW'(ROWS - 1)) ? '0 : row_idx + RIW'(1);
    assign cnt_inc = cnt + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SCAN;
            row_idx <= '0;
            col_lat <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_d;
            row_idx <= row_idx_d;
            col_lat <= col_lat_d;
            cnt     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state;
        row_idx_d = row_idx;
        col_lat_d = col_lat;
        cnt_d     = cnt;
        push      = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (any_low) begin
                        col_lat_d = low_col;
                        cnt_d     = 4'd1;
                        if (DB <= 4'd1) begin
                            push    = 1'b1;
                            state_d = PRESSED;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        row_idx_d = row_adv;
                    end
                end
                DEBOUNCE: begin
                    if (any_low && (low_col == col_lat)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DB) begin
                            push    = 1'b1;
                            state_d = PRESSED;
                        end
                    end else begin
                        row_idx_d = row_adv;
                        state_d   = SCAN;
                    end
                end
                PRESSED: begin
                    if (!any_low) begin
                        cnt_d   = 4'd1;
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (!any_low) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DB) begin
                            row_idx_d = row_adv;
                            state_d   = SCAN;
                        end
                    end else begin
                        state_d = PRESSED;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    // Row is frozen during DEBOUNCE, so the live row index is the latched one at push time.
    assign raw_code = KW'(int'(row_idx) * COLS + int'(low_col));

    always_comb begin
        case (raw_code[3:0])
            4'd0:    hex_code = 4'h1;
            4'd1:    hex_code = 4'h2;
            4'd2:    hex_code = 4'h3;
            4'd3:    hex_code = 4'hA;
            4'd4:    hex_code = 4'h4;
            4'd5:    hex_code = 4'h5;
            4'd6:    hex_code = 4'h6;
            4'd7:    hex_code = 4'hB;
            4'd8:    hex_code = 4'h7;
            4'd9:    hex_code = 4'h8;
            4'd10:   hex_code = 4'h9;
            4'd11:   hex_code = 4'hC;
            4'd12:   hex_code = 4'hE;
            4'd13:   hex_code = 4'h0;
            4'd14:   hex_code = 4'hF;
            default: hex_code = 4'hD;
        endcase
    end

    assign push_code = USE_HEX ? KW'(hex_code) : raw_code;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !fifo_empty && key_ready;
    // When full, the write slot is the head being popped this cycle, so overwriting it keeps order.
    assign push_ok    = push && (!fifo_full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            overflow <= push && !push_ok;
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= push_code;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    assign row       = ~(ROWS'(1) << row_idx);
    assign key_valid = !fifo_empty;
    assign key_code  = mem[rd_ptr[AW-1:0]];
    assign key_held  = (state == PRESSED) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench: a default 4x4 hex-map scanner (A) and a 3x5 raw-index scanner (B) driven by simple keypad models.
`timescale 1ns/1ps
module tb_keypad_scanner;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, key_ready, key_valid, key_held, overflow;
    logic [3:0] column, row, key_code, glitch;
    logic [3:0][3:0] keys;

    logic       rst_n_b, key_ready_b, key_valid_b, key_held_b, overflow_b;
    logic [4:0] column_b;
    logic [2:0] row_b;
    logic [3:0] key_code_b;
    logic [2:0][4:0] keys_b;

    keypad_scanner dut_a (
        .clk(clk), .rst_n(rst_n), .column(column), .row(row), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held), .overflow(overflow)
    );

    keypad_scanner #(.ROWS(3), .COLS(5), .MAP_HEX(0)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .column(column_b), .row(row_b), .key_code(key_code_b),
        .key_valid(key_valid_b), .key_ready(key_ready_b), .key_held(key_held_b), .overflow(overflow_b)
    );

    always_comb begin
        column = glitch;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r][c] && !row[r]) column[c] = 1'b0;
    end

    always_comb begin
        column_b = '1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++)
                if (keys_b[r][c] && !row_b[r]) column_b[c] = 1'b0;
    end

    int   ev_q [$];
    int   evb_q [$];
    int   ovf_cnt = 0;
    logic held_seen = 1'b0;

    always @(posedge clk) begin
        if (key_valid && key_ready) ev_q.push_back(int'(key_code));
        if (key_valid_b && key_ready_b) evb_q.push_back(int'(key_code_b));
        if (overflow) ovf_cnt++;
        if (key_held) held_seen = 1'b1;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_key(input bit sel, input int r, input int c, input logic v);
        if (sel) keys_b[r][c] = v;
        else keys[r][c] = v;
    endtask

    function automatic logic held_of(input bit sel);
        return sel ? key_held_b : key_held;
    endfunction

    function automatic logic row_on(input bit sel, input int r);
        return sel ? !row_b[r] : !row[r];
    endfunction

    task automatic wait_held(input bit sel, input logic want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (held_of(sel) == want) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Returns just after the tick edge on which row r became the strobed row.
    task automatic wait_row_enter(input bit sel, input int r, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && row_on(sel, r); i++) cycles(1);
        for (int i = 0; i < 200; i++) begin
            if (row_on(sel, r)) begin
                ok = 1'b1;
                break;
            end
            cycles(1);
        end
        check({tag, "_row_enter"}, int'(ok), 1);
    endtask

    task automatic press_release(input bit sel, input int r0, input int c0, input bit two,
                                 input int r1, input int c1, input int hold, input string tag);
        bit ok;
        set_key(sel, r0, c0, 1'b1);
        if (two) set_key(sel, r1, c1, 1'b1);
        wait_held(sel, 1'b1, ok);
        check({tag, "_held_rise"}, int'(ok), 1);
        cycles(hold);
        set_key(sel, r0, c0, 1'b0);
        if (two) set_key(sel, r1, c1, 1'b0);
        wait_held(sel, 1'b0, ok);
        check({tag, "_held_fall"}, int'(ok), 1);
        cycles(20);
    endtask

    typedef struct {
        bit sel;
        int r0;
        int c0;
        bit two;
        int r1;
        int c1;
        int exp;
    } vec_t;

    vec_t vecs [13];

    typedef struct {
        int k;
        int row_a;
        int row_b;
    } step_t;

    step_t steps [8];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        bit ok;

        vecs[0]  = '{1'b0, 0, 0, 1'b0, 0, 0, 'h1};
        vecs[1]  = '{1'b0, 0, 3, 1'b0, 0, 0, 'hA};
        vecs[2]  = '{1'b0, 1, 2, 1'b0, 0, 0, 'h6};
        vecs[3]  = '{1'b0, 2, 2, 1'b0, 0, 0, 'h9};
        vecs[4]  = '{1'b0, 3, 0, 1'b0, 0, 0, 'hE};
        vecs[5]  = '{1'b0, 3, 1, 1'b0, 0, 0, 'h0};
        vecs[6]  = '{1'b0, 3, 3, 1'b0, 0, 0, 'hD};
        vecs[7]  = '{1'b0, 0, 1, 1'b1, 0, 3, 'h2};
        vecs[8]  = '{1'b0, 3, 2, 1'b1, 3, 3, 'hF};
        vecs[9]  = '{1'b0, 2, 3, 1'b0, 0, 0, 'hC};
        vecs[10] = '{1'b1, 2, 4, 1'b0, 0, 0, 14};
        vecs[11] = '{1'b1, 1, 3, 1'b0, 0, 0, 8};
        vecs[12] = '{1'b1, 0, 0, 1'b0, 0, 0, 0};

        // k-th rising edge after reset release; ticks land on every 8th edge.
        steps[0] = '{7, 4'b1110, 3'b110};
        steps[1] = '{8, 4'b1101, 3'b101};
        steps[2] = '{15, 4'b1101, 3'b101};
        steps[3] = '{16, 4'b1011, 3'b011};
        steps[4] = '{23, 4'b1011, 3'b011};
        steps[5] = '{24, 4'b0111, 3'b110};
        steps[6] = '{31, 4'b0111, 3'b110};
        steps[7] = '{32, 4'b1110, 3'b101};

        rst_n = 1'b0;
        rst_n_b = 1'b0;
        key_ready = 1'b1;
        key_ready_b = 1'b1;
        keys = '0;
        keys_b = '0;
        glitch = 4'b1010;

        for (int i = 0; i < 12; i++) begin
            #7;
            glitch = ~glitch;
        end
        check("rst_row", int'(row), 4'b1110);
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_key_held", int'(key_held), 0);
        check("rst_key_code", int'(key_code), 0);
        check("rst_row_b", int'(row_b), 3'b110);

        glitch = '1;
        @(negedge clk);
        rst_n = 1'b1;
        rst_n_b = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            cycles(1);
            for (int s = 0; s < 8; s++) begin
                if (steps[s].k == k) begin
                    check($sformatf("row_step_a_k%0d", k), int'(row), steps[s].row_a);
                    check($sformatf("row_step_b_k%0d", k), int'(row_b), steps[s].row_b);
                end
            end
        end

        for (int i = 0; i < 13; i++) begin
            ev_q.delete();
            evb_q.delete();
            press_release(vecs[i].sel, vecs[i].r0, vecs[i].c0, vecs[i].two,
                          vecs[i].r1, vecs[i].c1, 200, $sformatf("vec%0d", i));
            if (vecs[i].sel) begin
                check($sformatf("vec%0d_count", i), evb_q.size(), 1);
                check($sformatf("vec%0d_code", i), (evb_q.size() > 0) ? evb_q[0] : -1, vecs[i].exp);
            end else begin
                check($sformatf("vec%0d_count", i), ev_q.size(), 1);
                check($sformatf("vec%0d_code", i), (ev_q.size() > 0) ? ev_q[0] : -1, vecs[i].exp);
            end
        end

        // Key 0 low for exactly one sampling tick, then high: debounce must reject it.
        ev_q.delete();
        wait_row_enter(1'b0, 3, "glitch");
        held_seen = 1'b0;
        keys[3][1] = 1'b1;
        cycles(8);
        keys[3][1] = 1'b0;
        cycles(60);
        check("glitch_events", ev_q.size(), 0);
        check("glitch_held", int'(held_seen), 0);

        // Key 0 released for one tick, re-closed for one tick, then released for good.
        ev_q.delete();
        keys[3][1] = 1'b1;
        wait_held(1'b0, 1'b1, ok);
        check("rbounce_held_rise", int'(ok), 1);
        cycles(40);
        keys[3][1] = 1'b0;
        cycles(8);
        keys[3][1] = 1'b1;
        cycles(8);
        check("rbounce_still_held", int'(key_held), 1);
        keys[3][1] = 1'b0;
        wait_held(1'b0, 1'b0, ok);
        check("rbounce_held_fall", int'(ok), 1);
        cycles(40);
        check("rbounce_events", ev_q.size(), 1);
        check("rbounce_code", (ev_q.size() > 0) ? ev_q[0] : -1, 'h0);

        // Fill the FIFO with keys 1..5 while stalled; the fifth is dropped.
        key_ready = 1'b0;
        ev_q.delete();
        ovf_cnt = 0;
        press_release(1'b0, 0, 0, 1'b0, 0, 0, 40, "fill1");
        press_release(1'b0, 0, 1, 1'b0, 0, 0, 40, "fill2");
        press_release(1'b0, 0, 2, 1'b0, 0, 0, 40, "fill3");
        press_release(1'b0, 1, 0, 1'b0, 0, 0, 40, "fill4");
        check("fill4_no_overflow", ovf_cnt, 0);
        press_release(1'b0, 1, 1, 1'b0, 0, 0, 40, "fill5");
        check("full_overflow_pulses", ovf_cnt, 1);
        check("full_key_valid", int'(key_valid), 1);
        check("full_head_code", int'(key_code), 'h1);

        // Key 6 pressed as row 1 becomes strobed: push lands on the third tick after, pop aligned to it.
        wait_row_enter(1'b0, 1, "simul");
        keys[1][2] = 1'b1;
        cycles(23);
        key_ready = 1'b1;
        cycles(1);
        key_ready = 1'b0;
        check("simul_held", int'(key_held), 1);
        keys[1][2] = 1'b0;
        wait_held(1'b0, 1'b0, ok);
        check("simul_held_fall", int'(ok), 1);
        cycles(10);
        check("simul_no_overflow", ovf_cnt, 1);
        check("simul_pop_count", ev_q.size(), 1);
        check("simul_pop_code", (ev_q.size() > 0) ? ev_q[0] : -1, 'h1);

        ev_q.delete();
        key_ready = 1'b1;
        cycles(10);
        check("drain_count", ev_q.size(), 4);
        check("drain0", (ev_q.size() > 0) ? ev_q[0] : -1, 'h2);
        check("drain1", (ev_q.size() > 1) ? ev_q[1] : -1, 'h3);
        check("drain2", (ev_q.size() > 2) ? ev_q[2] : -1, 'h4);
        check("drain3", (ev_q.size() > 3) ? ev_q[3] : -1, 'h6);
        check("drain_empty", int'(key_valid), 0);

        // Reset of scanner B while debouncing key 14 discards the press.
        evb_q.delete();
        wait_row_enter(1'b1, 2, "rstdb");
        keys_b[2][4] = 1'b1;
        cycles(12);
        rst_n_b = 1'b0;
        cycles(2);
        check("rstdb_row_b", int'(row_b), 3'b110);
        check("rstdb_held_b", int'(key_held_b), 0);
        keys_b[2][4] = 1'b0;
        cycles(2);
        rst_n_b = 1'b1;
        cycles(80);
        check("rstdb_events", evb_q.size(), 0);
        check("rstdb_valid_b", int'(key_valid_b), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
